// File: rtl/fpu_cmp_ctrl.sv
// Valid/ready control wrapper around the binary32 compare datapath (FEQ/FLT/FLE/FMIN/FMAX).
// S1 holds the accepted op and operands; S2 holds the final result, flags and tag.
module fpu_cmp_ctrl #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [2:0]       in_op_i,
    input  logic [31:0]      in_rs1_i,
    input  logic [31:0]      in_rs2_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      out_result_o,
    output logic [4:0]       out_fflags_o,
    output logic [TAG_W-1:0] out_tag_o,
    output logic             busy_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned OP_W  = 3;
    localparam int unsigned FLG_W = 5;
    localparam int unsigned EXP_W = 10;
    localparam int unsigned SIG_W = 24;
    localparam int unsigned CLS_W = 6;

    localparam int unsigned CLS_ZERO = 0;
    localparam int unsigned CLS_SUB  = 1;
    localparam int unsigned CLS_NORM = 2;
    localparam int unsigned CLS_INF  = 3;
    localparam int unsigned CLS_SNAN = 4;
    localparam int unsigned CLS_QNAN = 5;
    localparam int unsigned FLG_NV   = 4;

    localparam logic [OP_W-1:0] OP_FEQ  = 3'd0;
    localparam logic [OP_W-1:0] OP_FLT  = 3'd1;
    localparam logic [OP_W-1:0] OP_FLE  = 3'd2;
    localparam logic [OP_W-1:0] OP_FMIN = 3'd3;
    localparam logic [OP_W-1:0] OP_FMAX = 3'd4;

    localparam logic [XLEN-1:0] CANON_NAN = 32'h7FC0_0000;
    localparam logic [XLEN-1:0] SIGN_BIT  = 32'h8000_0000;

    logic                    s1_valid;
    logic                    s2_valid;
    logic                    s1_adv;
    logic                    s2_adv;
    logic [OP_W-1:0]         s1_op;
    logic [XLEN-1:0]         s1_rs1;
    logic [XLEN-1:0]         s1_rs2;
    logic [TAG_W-1:0]        s1_tag;

    logic [CLS_W-1:0]        cls_a;
    logic [CLS_W-1:0]        cls_b;
    logic signed [EXP_W-1:0] exp_a;
    logic signed [EXP_W-1:0] exp_b;
    logic [SIG_W-1:0]        sig_a;
    logic [SIG_W-1:0]        sig_b;
    logic                    nan_a;
    logic                    nan_b;
    logic                    any_nan;
    logic                    any_snan;
    logic                    both_zero;
    logic                    both_fin;
    logic                    mag_lt;
    logic                    mag_eq;
    logic                    fcmp_lt;
    logic                    fcmp_eq;
    logic [XLEN-1:0]         key_a;
    logic [XLEN-1:0]         key_b;
    logic                    lt;
    logic                    eq;
    logic                    le;
    logic                    ord_lt;
    logic [XLEN-1:0]         res_c;
    logic [FLG_W-1:0]        flg_c;

    function automatic logic [CLS_W-1:0] classify(input logic [XLEN-1:0] x);
        logic [CLS_W-1:0] c;
        c = '0;
        if (x[30:23] == 8'h00) begin
            if (x[22:0] == 23'd0) c[CLS_ZERO] = 1'b1;
            else                  c[CLS_SUB]  = 1'b1;
        end else if (x[30:23] == 8'hFF) begin
            if (x[22:0] == 23'd0) c[CLS_INF]  = 1'b1;
            else if (x[22])       c[CLS_QNAN] = 1'b1;
            else                  c[CLS_SNAN] = 1'b1;
        end else begin
            c[CLS_NORM] = 1'b1;
        end
        return c;
    endfunction

    function automatic logic signed [EXP_W-1:0] unpack_exp(input logic [7:0] e);
        return (e == 8'h00) ? -10'sd126 : ($signed({2'b00, e}) - 10'sd127);
    endfunction

    assign s2_adv      = !s2_valid || out_ready_i;
    assign s1_adv      = !s1_valid || s2_adv;
    assign in_ready_o  = s1_adv && !flush_i;
    assign out_valid_o = s2_valid;
    assign busy_o      = s1_valid || s2_valid;

    // Unpack and classify both S1 operands.
    always_comb begin
        cls_a     = classify(s1_rs1);
        cls_b     = classify(s1_rs2);
        exp_a     = unpack_exp(s1_rs1[30:23]);
        exp_b     = unpack_exp(s1_rs2[30:23]);
        sig_a     = {s1_rs1[30:23] != 8'h00, s1_rs1[22:0]};
        sig_b     = {s1_rs2[30:23] != 8'h00, s1_rs2[22:0]};
        nan_a     = cls_a[CLS_SNAN] || cls_a[CLS_QNAN];
        nan_b     = cls_b[CLS_SNAN] || cls_b[CLS_QNAN];
        any_nan   = nan_a || nan_b;
        any_snan  = cls_a[CLS_SNAN] || cls_b[CLS_SNAN];
        both_zero = cls_a[CLS_ZERO] && cls_b[CLS_ZERO];
        both_fin  = (|cls_a[CLS_NORM:CLS_ZERO]) && (|cls_b[CLS_NORM:CLS_ZERO]);
    end

    // FCMP datapath: sign/magnitude compare of finite operands.
    always_comb begin
        mag_lt  = (exp_a < exp_b) || ((exp_a == exp_b) && (sig_a < sig_b));
        mag_eq  = (exp_a == exp_b) && (sig_a == sig_b);
        fcmp_lt = 1'b0;
        fcmp_eq = 1'b0;
        if (s1_rs1[31] != s1_rs2[31]) begin
            fcmp_lt = s1_rs1[31];
        end else if (s1_rs1[31]) begin
            fcmp_lt = !mag_lt && !mag_eq;
            fcmp_eq = mag_eq;
        end else begin
            fcmp_lt = mag_lt;
            fcmp_eq = mag_eq;
        end
    end

    // Patch FCMP for signed zeros and infinities; NaN cases are masked later.
    always_comb begin
        key_a = s1_rs1[31] ? ~s1_rs1 : (s1_rs1 | SIGN_BIT);
        key_b = s1_rs2[31] ? ~s1_rs2 : (s1_rs2 | SIGN_BIT);
        lt    = 1'b0;
        eq    = 1'b0;
        if (both_zero) begin
            eq = 1'b1;
        end else if (both_fin) begin
            lt = fcmp_lt;
            eq = fcmp_eq;
        end else begin
            lt = key_a < key_b;
            eq = key_a == key_b;
        end
        le     = lt || eq;
        // min/max orders -0 below +0
        ord_lt = both_zero ? (s1_rs1[31] && !s1_rs2[31]) : lt;
    end

    always_comb begin
        res_c = '0;
        flg_c = '0;
        case (s1_op)
            OP_FEQ: begin
                res_c          = XLEN'(eq && !any_nan);
                flg_c[FLG_NV]  = any_snan;
            end
            OP_FLT: begin
                res_c          = XLEN'(lt && !any_nan);
                flg_c[FLG_NV]  = any_nan;
            end
            OP_FLE: begin
                res_c          = XLEN'(le && !any_nan);
                flg_c[FLG_NV]  = any_nan;
            end
            OP_FMIN: begin
                if (nan_a && nan_b) res_c = CANON_NAN;
                else if (nan_a)     res_c = s1_rs2;
                else if (nan_b)     res_c = s1_rs1;
                else                res_c = ord_lt ? s1_rs1 : s1_rs2;
                flg_c[FLG_NV] = any_snan;
            end
            OP_FMAX: begin
                if (nan_a && nan_b) res_c = CANON_NAN;
                else if (nan_a)     res_c = s1_rs2;
                else if (nan_b)     res_c = s1_rs1;
                else                res_c = ord_lt ? s1_rs2 : s1_rs1;
                flg_c[FLG_NV] = any_snan;
            end
            default: begin
                res_c = '0;
                flg_c = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_rs1   <= '0;
            s1_rs2   <= '0;
            s1_tag   <= '0;
        end else if (flush_i) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid_i;
            if (in_valid_i) begin
                s1_op  <= in_op_i;
                s1_rs1 <= in_rs1_i;
                s1_rs2 <= in_rs2_i;
                s1_tag <= in_tag_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s2_valid     <= 1'b0;
            out_result_o <= '0;
            out_fflags_o <= '0;
            out_tag_o    <= '0;
        end else if (flush_i) begin
            s2_valid <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result_o <= res_c;
                out_fflags_o <= flg_c;
                out_tag_o    <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_fpu_cmp_ctrl.sv
// Self-checking bench for fpu_cmp_ctrl: directed vectors, random stream with backpressure,
// stall, flush and asynchronous reset scenarios against a real-number reference model.
module tb_fpu_cmp_ctrl;

    localparam int unsigned TAG_W = 5;
    localparam int unsigned NVEC  = 18;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [31:0]      in_rs1;
    logic [31:0]      in_rs2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [4:0]       out_fflags;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fpu_cmp_ctrl #(.TAG_W(TAG_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_op_i(in_op),
        .in_rs1_i(in_rs1), .in_rs2_i(in_rs2), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
        .out_fflags_o(out_fflags), .out_tag_o(out_tag), .busy_o(busy)
    );

    // {op, rs1, rs2, expected result, expected fflags}
    localparam logic [103:0] VEC [NVEC] = '{
        {3'd1, 32'h3F800000, 32'h40000000, 32'h00000001, 5'h00},
        {3'd2, 32'h40000000, 32'h3F800000, 32'h00000000, 5'h00},
        {3'd0, 32'h7F800001, 32'h3F800000, 32'h00000000, 5'h10},
        {3'd0, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'h00},
        {3'd1, 32'h7FC00000, 32'h3F800000, 32'h00000000, 5'h10},
        {3'd0, 32'h00000000, 32'h80000000, 32'h00000001, 5'h00},
        {3'd1, 32'hFF800000, 32'hBF800000, 32'h00000001, 5'h00},
        {3'd2, 32'h7F800000, 32'h7F800000, 32'h00000001, 5'h00},
        {3'd3, 32'h00000000, 32'h80000000, 32'h80000000, 5'h00},
        {3'd4, 32'h7FC00000, 32'h40400000, 32'h40400000, 5'h00},
        {3'd4, 32'h7F800001, 32'h7F800001, 32'h7FC00000, 5'h10},
        {3'd4, 32'h80000000, 32'h00000000, 32'h00000000, 5'h00},
        {3'd5, 32'h3F800000, 32'h40000000, 32'h00000000, 5'h00},
        {3'd1, 32'h00000001, 32'h00000002, 32'h00000001, 5'h00},
        {3'd1, 32'hBF800000, 32'h00000000, 32'h00000001, 5'h00},
        {3'd2, 32'h80000001, 32'h80000000, 32'h00000001, 5'h00},
        {3'd0, 32'h7F800000, 32'h7F7FFFFF, 32'h00000000, 5'h00},
        {3'd1, 32'hC0000000, 32'hBF800000, 32'h00000001, 5'h00}
    };

    function automatic real f2r(input logic [31:0] x);
        real m;
        int  ex;
        if (x[30:23] == 8'hFF) return x[31] ? -1.0e300 : 1.0e300;
        if (x[30:23] == 8'h00) begin
            m  = real'(x[22:0]) / 8388608.0;
            ex = -126;
        end else begin
            m  = 1.0 + real'(x[22:0]) / 8388608.0;
            ex = int'(x[30:23]) - 127;
        end
        for (int i = 0; i < ex; i++) m = m * 2.0;
        for (int i = 0; i > ex; i--) m = m * 0.5;
        return x[31] ? -m : m;
    endfunction

    // Reference: returns {fflags, result}
    function automatic logic [36:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit na, nb, sa, sb;
        real ra, rb;
        logic [31:0] r;
        logic [4:0]  f;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        sa = na && !a[22];
        sb = nb && !b[22];
        ra = f2r(a);
        rb = f2r(b);
        r  = 32'd0;
        f  = 5'd0;
        case (op)
            3'd0: begin f[4] = sa || sb; r[0] = !(na || nb) && (ra == rb); end
            3'd1: begin f[4] = na || nb; r[0] = !(na || nb) && (ra <  rb); end
            3'd2: begin f[4] = na || nb; r[0] = !(na || nb) && (ra <= rb); end
            3'd3, 3'd4: begin
                f[4] = sa || sb;
                if (na && nb)                      r = 32'h7FC00000;
                else if (na)                       r = b;
                else if (nb)                       r = a;
                else if (ra == 0.0 && rb == 0.0) begin
                    if (op == 3'd3) r = (a[31] || b[31]) ? 32'h80000000 : 32'h00000000;
                    else            r = (a[31] && b[31]) ? 32'h80000000 : 32'h00000000;
                end
                else if (op == 3'd3)               r = (rb < ra) ? b : a;
                else                               r = (rb > ra) ? b : a;
            end
            default: ;
        endcase
        return {f, r};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] x;
        x = $urandom;
        case ($urandom_range(0, 9))
            0: case ($urandom_range(0, 11))
                   0: x = 32'h00000000;  1: x = 32'h80000000;  2: x = 32'h7F800000;
                   3: x = 32'hFF800000;  4: x = 32'h7FC00000;  5: x = 32'h7F800001;
                   6: x = 32'hFFA00000;  7: x = 32'h00000001;  8: x = 32'h807FFFFF;
                   9: x = 32'h3F800000; 10: x = 32'hBF800000; default: x = 32'h7F7FFFFF;
               endcase
            1: x[30:23] = 8'h00;
            2: x[30:22] = {8'hFF, 1'b1};
            default: ;
        endcase
        return x;
    endfunction

    // Issue one op with out_ready held high; returns its outputs and latency in cycles.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [TAG_W-1:0] tag, output logic [31:0] res,
                         output logic [4:0] fl, output logic [TAG_W-1:0] otag, output int lat);
        int k;
        in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag;
        in_valid = 1'b1; out_ready = 1'b1; lat = -1; k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        res = out_result; fl = out_fflags; otag = out_tag;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || out_result !== 32'd0 || out_fflags !== 5'd0 || out_tag !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b res=%h fl=%h tag=%h busy=%b, want all zero",
                     out_valid, out_result, out_fflags, out_tag, busy);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [103:0]     v;
        logic [31:0]      res;
        logic [4:0]       fl;
        logic [TAG_W-1:0] otag;
        int               lat;
        for (int i = 0; i < int'(NVEC); i++) begin
            v = VEC[i];
            do_op(v[103:101], v[100:69], v[68:37], TAG_W'(i + 3), res, fl, otag, lat);
            n_tests++;
            if (lat != 2) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d cycles, want 2", i, lat);
            end
            n_tests++;
            if (res !== v[36:5] || fl !== v[4:0] || otag !== TAG_W'(i + 3)) begin
                n_fail++;
                $display("FAIL directed[%0d] op=%0d a=%h b=%h: got res=%h fl=%h tag=%0d, want res=%h fl=%h tag=%0d",
                         i, v[103:101], v[100:69], v[68:37], res, fl, otag, v[36:5], v[4:0], TAG_W'(i + 3));
            end
        end
    endtask

    task automatic test_random(input int n_ops);
        logic [36:0]      expq[$];
        logic [TAG_W-1:0] tagq[$];
        logic [36:0]      e;
        logic [TAG_W-1:0] et;
        logic [31:0]      hr;
        logic [4:0]       hf;
        logic [TAG_W-1:0] ht;
        int  sent, got, cyc;
        bit  acc, take, held;
        sent = 0; got = 0; cyc = 0; held = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1;
        while (got < n_ops && cyc < n_ops * 20) begin
            if (!in_valid && sent < n_ops && $urandom_range(0, 3) != 0) begin
                in_op  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                in_rs1 = rand_fp();
                case ($urandom_range(0, 7))
                    0, 1:    in_rs2 = in_rs1;
                    2:       in_rs2 = in_rs1 ^ 32'h80000000;
                    3:       in_rs2 = in_rs1 + 32'd1;
                    default: in_rs2 = rand_fp();
                endcase
                in_tag   = TAG_W'(sent);
                in_valid = 1'b1;
            end
            @(negedge clk);
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (held) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_result !== hr || out_fflags !== hf || out_tag !== ht) begin
                    n_fail++;
                    $display("FAIL random_stall_hold: got v=%b res=%h fl=%h tag=%0d, want v=1 res=%h fl=%h tag=%0d",
                             out_valid, out_result, out_fflags, out_tag, hr, hf, ht);
                end
            end
            held = out_valid && !out_ready;
            hr = out_result; hf = out_fflags; ht = out_tag;
            if (take) begin
                n_tests++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_spurious: got res=%h tag=%0d, want no output", out_result, out_tag);
                end else begin
                    e  = expq.pop_front();
                    et = tagq.pop_front();
                    if (out_result !== e[31:0] || out_fflags !== e[36:32] || out_tag !== et) begin
                        n_fail++;
                        $display("FAIL random_result: got res=%h fl=%h tag=%0d, want res=%h fl=%h tag=%0d",
                                 out_result, out_fflags, out_tag, e[31:0], e[36:32], et);
                    end
                end
                got++;
            end
            if (acc) begin
                expq.push_back(ref_op(in_op, in_rs1, in_rs2));
                tagq.push_back(in_tag);
                sent++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            out_ready = ($urandom_range(0, 9) < 7);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (got != n_ops || expq.size() != 0) begin
            n_fail++;
            $display("FAIL random_count: got %0d results (%0d pending), want %0d", got, expq.size(), n_ops);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0]      a [4];
        logic [31:0]      b [4];
        logic [2:0]       o [4];
        logic [36:0]      ev [4];
        logic [31:0]      hr;
        logic [4:0]       hf;
        logic [TAG_W-1:0] ht;
        int  idx, got;
        bit  acc, take, held;
        idx = 0; got = 0; held = 1'b0;
        for (int i = 0; i < 4; i++) begin
            o[i] = 3'($urandom_range(0, 4)); a[i] = rand_fp(); b[i] = rand_fp();
            ev[i] = ref_op(o[i], a[i], b[i]);
        end
        out_ready = 1'b0;
        in_op = o[0]; in_rs1 = a[0]; in_rs2 = b[0]; in_tag = TAG_W'(10); in_valid = 1'b1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                n_tests++;
                if (in_ready !== 1'b0 || idx != 2) begin
                    n_fail++;
                    $display("FAIL b2b_ready_drop: in_ready=%b accepts=%0d, want 0 after 2", in_ready, idx);
                end
            end
            if (held) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_result !== hr || out_fflags !== hf || out_tag !== ht) begin
                    n_fail++;
                    $display("FAIL b2b_stall_hold: got v=%b res=%h tag=%0d, want v=1 res=%h tag=%0d",
                             out_valid, out_result, out_tag, hr, ht);
                end
            end
            held = out_valid && !out_ready;
            hr = out_result; hf = out_fflags; ht = out_tag;
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) begin
                n_tests++;
                if (got >= 4) begin
                    n_fail++;
                    $display("FAIL b2b_extra: got tag=%0d, want no fifth result", out_tag);
                end else if (out_tag !== TAG_W'(10 + got) || out_result !== ev[got][31:0] || out_fflags !== ev[got][36:32]) begin
                    n_fail++;
                    $display("FAIL b2b_order[%0d]: got res=%h fl=%h tag=%0d, want res=%h fl=%h tag=%0d",
                             got, out_result, out_fflags, out_tag, ev[got][31:0], ev[got][36:32], TAG_W'(10 + got));
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) begin
                idx++;
                if (idx < 4) begin
                    in_op = o[idx]; in_rs1 = a[idx]; in_rs2 = b[idx]; in_tag = TAG_W'(10 + idx);
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = (cyc >= 4);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_tests++;
        if (got != 4 || idx != 4) begin
            n_fail++;
            $display("FAIL b2b_count: accepted %0d returned %0d, want 4 and 4", idx, got);
        end
    endtask

    task automatic test_flush();
        logic [31:0]      res;
        logic [4:0]       fl;
        logic [TAG_W-1:0] otag;
        int               lat;
        bit               seen;
        out_ready = 1'b1;
        in_op = 3'd1; in_rs1 = 32'h3F800000; in_rs2 = 32'h40000000; in_tag = TAG_W'(20); in_valid = 1'b1;
        @(posedge clk); #1;
        in_op = 3'd4; in_tag = TAG_W'(21);
        @(posedge clk); #1;
        flush = 1'b1; in_op = 3'd0; in_tag = TAG_W'(22);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_cycle: in_ready=%b busy=%b, want 0 and 1", in_ready, busy);
        end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid || busy) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_kill: got output or busy after flush, want none");
        end
        do_op(3'd2, 32'hBF800000, 32'h3F800000, TAG_W'(23), res, fl, otag, lat);
        n_tests++;
        if (res !== 32'd1 || fl !== 5'd0 || otag !== TAG_W'(23) || lat != 2) begin
            n_fail++;
            $display("FAIL flush_next: got res=%h fl=%h tag=%0d lat=%0d, want res=1 fl=0 tag=23 lat=2",
                     res, fl, otag, lat);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_op = 3'd3; in_rs1 = 32'h40000000; in_rs2 = 32'h3F800000; in_tag = TAG_W'(5); in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: busy=%b out_valid=%b, want 1 1", busy, out_valid);
        end
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_result !== 32'd0 || out_tag !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_async: busy=%b out_valid=%b res=%h tag=%0d, want all zero",
                     busy, out_valid, out_result, out_tag);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_after: busy=%b out_valid=%b in_ready=%b, want 0 0 1", busy, out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random(300);
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
